mont_redc: RTL

MONT_REDC -- requirements
Module: mont_redc

---
 rtl/mont_redc_if.sv | 16 +
 rtl/mont_redc.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mont_redc_if.sv
// Request/response bundle between a requester and the mont_redc reduction core.
interface mont_redc_if #(
  parameter int NW = 256,
  parameter int PW = 2 * NW
);
  logic          start;
  logic [PW-1:0] VT;
  logic [NW-1:0] VN;
  logic [NW-1:0] VNI;
  logic [NW-1:0] VR;
  logic          busy;
  logic          done;

  modport master (output start, VT, VN, VNI, input VR, busy, done);
  modport slave  (input start, VT, VN, VNI, output VR, busy, done);
endinterface

// File: rtl/mont_redc.sv
// Word-serial Montgomery reduction: VR = VT * 2^-NW mod VN, one DW-bit word per Q/ADD pair,
// followed by a single conditional subtraction.
module mont_redc #(
  parameter int NW = 256,
  parameter int DW = 32,
  parameter int PW = 2 * NW
) (
  input logic        clk,
  input logic        resetn,
  mont_redc_if.slave bus
);
  localparam int NWW = NW / DW;
  localparam int IW  = (NWW > 1) ? $clog2(NWW) : 1;

  typedef enum logic [2:0] {IDLE, Q, ADD, SUB, DONE} state_t;

  state_t state;
  state_t state_next;

  logic [PW:0]      t;
  logic [NW-1:0]    n_reg;
  logic [DW-1:0]    ni_reg;
  logic [DW-1:0]    q_word;
  logic [IW-1:0]    i;
  logic [NW-1:0]    vr;
  logic             busy;
  logic             done;

  logic [DW-1:0]    t_word;
  logic [NW+DW-1:0] qn;
  logic [PW:0]      addend;
  logic [NW:0]      h;
  logic [NW-1:0]    h_minus_n;
  logic             h_ge_n;
  logic             last_word;
  logic [NW-DW-1:0] unused_vni;

  assign unused_vni = bus.VNI[NW-1:DW];

  assign t_word    = t[DW*i +: DW];
  assign qn        = {{NW{1'b0}}, q_word} * {{DW{1'b0}}, n_reg};
  assign addend    = {{(PW+1-NW-DW){1'b0}}, qn} << (DW * i);
  assign h         = t[NW +: NW+1];
  assign h_ge_n    = (h >= {1'b0, n_reg});
  assign h_minus_n = NW'(h - {1'b0, n_reg});
  assign last_word = (i == IW'(NWW - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = Q;
        end
      end
      Q: begin
        busy       = 1'b1;
        state_next = ADD;
      end
      ADD: begin
        busy       = 1'b1;
        state_next = last_word ? SUB : Q;
      end
      SUB: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands are captured at start so the caller may change its inputs while we run.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      t      <= '0;
      n_reg  <= '0;
      ni_reg <= '0;
      q_word <= '0;
      i      <= '0;
      vr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            t      <= {1'b0, bus.VT};
            i      <= '0;
            n_reg  <= bus.VN;
            ni_reg <= bus.VNI[DW-1:0];
          end
        end
        Q:   q_word <= t_word * ni_reg;
        ADD: begin
          t <= t + addend;
          i <= i + IW'(1);
        end
        SUB: vr <= h_ge_n ? h_minus_n : h[NW-1:0];
        default: ;
      endcase
    end
  end

  assign bus.VR   = vr;
  assign bus.busy = busy;
  assign bus.done = done;

  // Each ADD cancels one low word, so the whole low half must be zero by SUB.
  low_half_zero: assert property (@(posedge clk) disable iff (!resetn)
    (state == SUB) |-> (t[NW-1:0] == '0));

endmodule
